// File: rtl/mac_frame_accum_if.sv
// Handshake bundle between the multiply-add result stream, the frame
// accumulator and its downstream consumer.
interface mac_frame_accum_if #(
    parameter int Const = 8,
    parameter int ACC_W = 2*Const+2
);
    logic [2*Const-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               clear;
    logic [ACC_W-1:0]   out_data;
    logic               out_ovf;
    logic [7:0]         out_frame;
    logic               out_valid;
    logic               out_ready;

    // master: producer of samples and consumer of totals
    modport master (
        output in_data, in_valid, clear, out_ready,
        input  in_ready, out_data, out_ovf, out_frame, out_valid
    );

    // slave: the accumulator itself
    modport slave (
        input  in_data, in_valid, clear, out_ready,
        output in_ready, out_data, out_ovf, out_frame, out_valid
    );
endinterface

// File: rtl/mac_frame_accum.sv
// Frame accumulator: sums N unsigned 2*Const-bit samples into a saturating
// ACC_W-bit total and holds it on a valid/ready output until taken.
module mac_frame_accum #(
    parameter int Const = 8,
    parameter int N     = 4,
    parameter int ACC_W = 2*Const+2
) (
    input  logic              clk,
    input  logic              reset,
    mac_frame_accum_if.slave  bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(N-1);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        cnt;
    logic              ovf_int;
    logic [ACC_W-1:0]  out_data_r;
    logic              out_ovf_r;
    logic [7:0]        out_frame_r;
    logic              out_valid_r;

    logic              accept;
    logic [ACC_W:0]    sum;

    // The extra top bit of the sum is set exactly when the true sum
    // exceeds the largest ACC_W-bit value.
    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] x);
        return x[ACC_W] ? {ACC_W{1'b1}} : x[ACC_W-1:0];
    endfunction

    function automatic logic sat_hit(input logic [ACC_W:0] x);
        return x[ACC_W];
    endfunction

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_data  = out_data_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.out_frame = out_frame_r;
    assign bus.out_valid = out_valid_r;

    assign accept = bus.in_valid & (state == ACCUM);
    assign sum    = {1'b0, acc} + {{(ACC_W+1-2*Const){1'b0}}, bus.in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf_int     <= 1'b0;
            out_data_r  <= '0;
            out_ovf_r   <= 1'b0;
            out_frame_r <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    // clear outranks any sample, including a frame-completing one
                    if (bus.clear) begin
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_int <= 1'b0;
                    end else if (accept) begin
                        if (cnt == LAST) begin
                            out_data_r  <= sat(sum);
                            out_ovf_r   <= ovf_int | sat_hit(sum);
                            out_valid_r <= 1'b1;
                            state       <= HOLD;
                            acc         <= '0;
                            cnt         <= '0;
                            ovf_int     <= 1'b0;
                        end else begin
                            acc     <= sat(sum);
                            cnt     <= cnt + 8'd1;
                            ovf_int <= ovf_int | sat_hit(sum);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_frame_r <= out_frame_r + 8'd1;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
